// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch port and the
// data port, with one transaction outstanding, a starvation guard for fetch and a watchdog.
module unified_mem_arbiter #(
  parameter int TIMEOUT    = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_req,
  output logic        m_we,
  output logic        m_size,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic [63:0] m_rdata,
  input  logic        m_ack,
  output logic        timeout_err
);

  localparam int WW = $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_cnt_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic          we_nx, size_nx, if_valid_nx, d_valid_nx, terr_nx;
  logic [63:0]   addr_nx, wdata_nx, d_rdata_nx;
  logic [31:0]   if_rdata_nx;
  logic          d_any, if_ok, d_ok, grant_if, grant_d;

  // A port whose valid is high this cycle still shows its old request, so it is not eligible.
  assign d_any     = d_read | d_write;
  assign if_ok     = if_req & ~if_valid;
  assign d_ok      = d_any & ~d_valid;
  assign m_req     = (state != IDLE);
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_any & ~d_valid;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    starve_nx   = starve_cnt;
    we_nx       = m_we;
    size_nx     = m_size;
    addr_nx     = m_addr;
    wdata_nx    = m_wdata;
    if_rdata_nx = if_rdata;
    d_rdata_nx  = d_rdata;
    if_valid_nx = 1'b0;
    d_valid_nx  = 1'b0;
    terr_nx     = timeout_err;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    if (!if_req) starve_nx = '0;
    unique case (state)
      IDLE: begin
        wait_cnt_nx = '0;
        grant_if    = if_ok & (~d_ok | (starve_cnt == STARVE_TOP));
        grant_d     = d_ok & ~grant_if;
        if (grant_if) begin
          state_nx  = IF_WAIT;
          we_nx     = 1'b0;
          size_nx   = 1'b0;
          addr_nx   = if_addr;
          wdata_nx  = '0;
          starve_nx = '0;
        end else if (grant_d) begin
          // A store wins when both load and store are raised together.
          state_nx = D_WAIT;
          we_nx    = d_write;
          size_nx  = 1'b1;
          addr_nx  = d_addr;
          wdata_nx = d_wdata;
          if (if_req && starve_cnt != STARVE_TOP) starve_nx = starve_cnt + SW'(1);
        end
      end
      IF_WAIT, D_WAIT: begin
        if (m_ack || wait_cnt == WAIT_LAST) begin
          state_nx    = IDLE;
          wait_cnt_nx = '0;
          if (!m_ack) terr_nx = 1'b1;
          if (state == IF_WAIT) begin
            if_valid_nx = 1'b1;
            if_rdata_nx = m_ack ? m_rdata[31:0] : 32'h0;
          end else begin
            d_valid_nx = 1'b1;
            d_rdata_nx = (m_ack && !m_we) ? m_rdata : 64'h0;
          end
        end else begin
          wait_cnt_nx = wait_cnt + WW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      m_we        <= 1'b0;
      m_size      <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_valid    <= 1'b0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      starve_cnt  <= starve_nx;
      m_we        <= we_nx;
      m_size      <= size_nx;
      m_addr      <= addr_nx;
      m_wdata     <= wdata_nx;
      if_rdata    <= if_rdata_nx;
      d_rdata     <= d_rdata_nx;
      if_valid    <= if_valid_nx;
      d_valid     <= d_valid_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int TIMEOUT    = 256;
  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        if_req, d_read, d_write, m_ack;
  logic [63:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, m_addr, m_wdata;
  logic        if_valid, d_valid, stall_if, stall_mem, m_req, m_we, m_size, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  unified_mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .resetl(resetl),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall_if(stall_if), .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rst, ifr;
    logic [63:0] ia;
    logic        dr, dw;
    logic [63:0] da, dwd;
    logic        ack;
    logic [63:0] mrd;
    logic        cbus, ereq, ewe, esz;
    logic [63:0] eaddr, ewd;
    logic        eifv;
    logic [31:0] eifd;
    logic        edv;
    logic [63:0] edd;
    logic        esif, esm;
  } vec_t;

  vec_t tbl [18];

  // Transaction-level reference: which port owns the memory and for how many cycles.
  int          e_busy, e_elapsed, e_starve;
  logic        e_we, e_size, e_ifv, e_dv, e_terr;
  logic [63:0] e_addr, e_wdata, e_dd;
  logic [31:0] e_ifd;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    resetl  = v.rst;
    if_req  = v.ifr;
    if_addr = v.ia;
    d_read  = v.dr;
    d_write = v.dw;
    d_addr  = v.da;
    d_wdata = v.dwd;
    m_ack   = v.ack;
    m_rdata = v.mrd;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    resetl = 1'b0; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; m_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
  endtask

  task automatic model_reset();
    e_busy = 0; e_elapsed = 0; e_starve = 0;
    e_we = 1'b0; e_size = 1'b0; e_ifv = 1'b0; e_dv = 1'b0; e_terr = 1'b0;
    e_addr = '0; e_wdata = '0; e_dd = '0; e_ifd = '0;
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic n_ifv, n_dv, want_if, want_d;
    if (!resetl) begin
      model_reset();
      return;
    end
    n_ifv = 1'b0;
    n_dv  = 1'b0;
    if (!if_req) e_starve = 0;
    if (e_busy == 0) begin
      want_if = if_req && !e_ifv;
      want_d  = (d_read || d_write) && !e_dv;
      if (want_if && (!want_d || e_starve == STARVE_MAX)) begin
        e_busy = 1; e_elapsed = 0; e_we = 1'b0; e_size = 1'b0; e_addr = if_addr; e_starve = 0;
      end else if (want_d) begin
        e_busy = 2; e_elapsed = 0; e_we = d_write; e_size = 1'b1; e_addr = d_addr; e_wdata = d_wdata;
        if (if_req) e_starve = (e_starve + 1 > STARVE_MAX) ? STARVE_MAX : e_starve + 1;
      end
    end else begin
      e_elapsed++;
      if (m_ack || e_elapsed == TIMEOUT) begin
        if (e_busy == 1) begin
          n_ifv = 1'b1;
          e_ifd = m_ack ? m_rdata[31:0] : 32'h0;
        end else begin
          n_dv = 1'b1;
          e_dd = (m_ack && !e_we) ? m_rdata : 64'h0;
        end
        if (!m_ack) e_terr = 1'b1;
        e_busy = 0;
      end
    end
    e_ifv = n_ifv;
    e_dv  = n_dv;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   dcyc, icyc, cnt, reqcnt, ifv_count, d_first, d_between;
    logic prev_dv, prev_ifv, seen;
    logic [63:0] first_addr, got;
    int   k;

    tbl[0]  = '{1'b0,1'b0,64'h0, 1'b0,1'b0,64'h0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,64'h100, 1'b0,1'b0,64'h0,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b1,1'b0};
    tbl[2]  = '{1'b1,1'b1,64'h100, 1'b0,1'b0,64'h0,64'h0, 1'b1,64'hD2800020, 1'b1,1'b1,1'b0,1'b0,64'h100,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b1,64'h100, 1'b0,1'b0,64'h0,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b1,32'hD2800020, 1'b0,64'h0, 1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,64'h0, 1'b0,1'b0,64'h0,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,64'h0, 1'b0,1'b1,64'h40,64'hDEADBEEF, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[6]  = '{1'b1,1'b0,64'h0, 1'b0,1'b1,64'h40,64'hDEADBEEF, 1'b0,64'h0, 1'b1,1'b1,1'b1,1'b1,64'h40,64'hDEADBEEF, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[7]  = '{1'b1,1'b0,64'h0, 1'b0,1'b1,64'h40,64'hDEADBEEF, 1'b1,64'h1234, 1'b1,1'b1,1'b1,1'b1,64'h40,64'hDEADBEEF, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[8]  = '{1'b1,1'b0,64'h0, 1'b0,1'b1,64'h40,64'hDEADBEEF, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b1,64'h0, 1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,64'h0, 1'b1,1'b0,64'h80,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[10] = '{1'b1,1'b0,64'h0, 1'b1,1'b0,64'h80,64'h0, 1'b1,64'hCAFEF00D12345678, 1'b1,1'b1,1'b0,1'b1,64'h80,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[11] = '{1'b1,1'b0,64'h0, 1'b1,1'b0,64'h80,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b1,64'hCAFEF00D12345678, 1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,64'h0, 1'b0,1'b0,64'h0,64'h0, 1'b1,64'h77, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b0};
    tbl[13] = '{1'b1,1'b0,64'h0, 1'b0,1'b0,64'h0,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,64'h0, 1'b1,1'b1,64'h48,64'h5, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[15] = '{1'b1,1'b0,64'h0, 1'b1,1'b1,64'h48,64'h5, 1'b1,64'hFF, 1'b1,1'b1,1'b1,1'b1,64'h48,64'h5, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b1};
    tbl[16] = '{1'b1,1'b0,64'h0, 1'b1,1'b1,64'h48,64'h5, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b1,64'h0, 1'b0,1'b0};
    tbl[17] = '{1'b1,1'b0,64'h0, 1'b0,1'b0,64'h0,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,64'h0,64'h0, 1'b0,32'h0, 1'b0,64'h0, 1'b0,1'b0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      apply_stimulus(tbl[i]);
      #1;
      check_output($sformatf("tbl[%0d] m_req", i), m_req, tbl[i].ereq);
      check_output($sformatf("tbl[%0d] if_valid", i), if_valid, tbl[i].eifv);
      check_output($sformatf("tbl[%0d] d_valid", i), d_valid, tbl[i].edv);
      check_output($sformatf("tbl[%0d] stall_if", i), stall_if, tbl[i].esif);
      check_output($sformatf("tbl[%0d] stall_mem", i), stall_mem, tbl[i].esm);
      check_output($sformatf("tbl[%0d] timeout_err", i), timeout_err, 1'b0);
      if (tbl[i].cbus) begin
        check_output($sformatf("tbl[%0d] m_we", i), m_we, tbl[i].ewe);
        check_output($sformatf("tbl[%0d] m_size", i), m_size, tbl[i].esz);
        check_output($sformatf("tbl[%0d] m_addr", i), m_addr, tbl[i].eaddr);
        if (tbl[i].ewe || !tbl[i].ereq) check_output($sformatf("tbl[%0d] m_wdata", i), m_wdata, tbl[i].ewd);
      end
      if (tbl[i].eifv || (tbl[i].cbus && !tbl[i].ereq))
        check_output($sformatf("tbl[%0d] if_rdata", i), if_rdata, tbl[i].eifd);
      if (tbl[i].edv || (tbl[i].cbus && !tbl[i].ereq))
        check_output($sformatf("tbl[%0d] d_rdata", i), d_rdata, tbl[i].edd);
    end

    // Simultaneous fetch and load, memory answers on the third m_req cycle.
    do_reset();
    dcyc = -1; icyc = -1; cnt = 0; seen = 1'b0; prev_dv = 1'b0; prev_ifv = 1'b0; first_addr = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        if_req = 1'b1; if_addr = 64'h200; d_read = 1'b1; d_addr = 64'h300;
      end else begin
        if (prev_dv) d_read = 1'b0;
        if (prev_ifv) if_req = 1'b0;
      end
      #1;
      if (d_valid && dcyc < 0) dcyc = c;
      if (if_valid && icyc < 0) icyc = c;
      if (m_req && !seen) begin seen = 1'b1; first_addr = m_addr; end
      prev_dv = d_valid; prev_ifv = if_valid;
      if (m_req) begin
        cnt++;
        m_ack = (cnt == 3);
        if (cnt == 3) cnt = 0;
      end else begin
        m_ack = 1'b0;
      end
    end
    check_output("contend first grant addr", first_addr, 64'h300);
    check_output("contend d_valid cycle", dcyc, 4);
    check_output("contend if_valid cycle", icyc, 8);

    // Data port requesting back to back while fetch waits.
    do_reset();
    ifv_count = 0; d_first = 0; d_between = 0; prev_dv = 1'b0; prev_ifv = 1'b0;
    for (int c = 0; c < 80 && ifv_count < 2; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        if_req = 1'b1; if_addr = 64'h1000; d_read = 1'b1; d_addr = 64'h2000;
      end else begin
        if (prev_ifv) if_addr = if_addr + 64'h4;
        if (prev_dv) d_addr = d_addr + 64'h8;
      end
      m_rdata = {32'h0, c};
      #1;
      if (d_valid) begin
        if (ifv_count == 0) d_first++;
        else d_between++;
      end
      if (if_valid) ifv_count++;
      prev_dv = d_valid; prev_ifv = if_valid;
      m_ack = m_req;
    end
    check_output("starve fetch served twice", ifv_count, 2);
    check_output("starve data before first fetch bounded", (d_first >= 1 && d_first <= STARVE_MAX), 1'b1);
    check_output("starve data between fetches bounded", (d_between >= 1 && d_between <= STARVE_MAX), 1'b1);

    // Memory never answers a load.
    do_reset();
    reqcnt = 0; seen = 1'b0; got = 64'hX; prev_dv = 1'b0;
    for (int c = 0; c < 270; c++) begin
      @(negedge CLK);
      if (c == 0) begin d_read = 1'b1; d_addr = 64'h500; end
      else if (prev_dv) d_read = 1'b0;
      m_rdata = 64'hA5A5A5A5A5A5A5A5;
      m_ack = 1'b0;
      #1;
      if (m_req) reqcnt++;
      if (d_valid && !seen) begin seen = 1'b1; got = d_rdata; end
      prev_dv = d_valid;
    end
    check_output("timeout m_req cycles", reqcnt, TIMEOUT);
    check_output("timeout d_valid seen", seen, 1'b1);
    check_output("timeout d_rdata", got, 64'h0);
    check_output("timeout m_req low", m_req, 1'b0);
    check_output("timeout_err sticky", timeout_err, 1'b1);
    seen = 1'b0; got = 64'hX; prev_ifv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (c == 0) begin if_req = 1'b1; if_addr = 64'h600; end
      else if (prev_ifv) if_req = 1'b0;
      m_rdata = 64'h11223344AABBCCDD;
      #1;
      if (if_valid && !seen) begin seen = 1'b1; got = {32'h0, if_rdata}; end
      prev_ifv = if_valid;
      m_ack = m_req;
    end
    check_output("post-timeout fetch seen", seen, 1'b1);
    check_output("post-timeout if_rdata", got, 64'hAABBCCDD);
    check_output("post-timeout timeout_err", timeout_err, 1'b1);

    // Reset while a load is outstanding, then a stale ack.
    do_reset();
    @(negedge CLK);
    d_read = 1'b1; d_addr = 64'h700; m_ack = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      #1;
      k++;
    end while (!m_req && k < 5);
    check_output("midrst m_req before", m_req, 1'b1);
    @(negedge CLK);
    resetl = 1'b0; d_read = 1'b0;
    @(negedge CLK);
    resetl = 1'b1; m_ack = 1'b1; m_rdata = 64'h99;
    #1;
    check_output("midrst m_req after", m_req, 1'b0);
    check_output("midrst d_valid after", d_valid, 1'b0);
    check_output("midrst timeout_err", timeout_err, 1'b0);
    @(negedge CLK);
    m_ack = 1'b0;
    #1;
    check_output("midrst late ack d_valid", d_valid, 1'b0);
    check_output("midrst late ack m_req", m_req, 1'b0);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    prev_ifv = 1'b0; prev_dv = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      resetl = ($urandom_range(0, 199) != 0);
      if ((if_req && prev_ifv) || (!if_req && $urandom_range(0, 2) == 0)) begin
        if_req  = $urandom_range(0, 1) == 1;
        if_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (((d_read || d_write) && prev_dv) || (!(d_read || d_write) && $urandom_range(0, 2) == 0)) begin
        k = $urandom_range(0, 3);
        d_read  = (k == 1) || (k == 3);
        d_write = (k == 2) || (k == 3);
        d_addr  = {$urandom, $urandom} & ~64'h7;
        d_wdata = {$urandom, $urandom};
      end
      m_rdata = {$urandom, $urandom};
      #1;
      check_output("rnd m_req", m_req, e_busy != 0);
      if (e_busy != 0) begin
        check_output("rnd m_we", m_we, e_we);
        check_output("rnd m_size", m_size, e_size);
        check_output("rnd m_addr", m_addr, e_addr);
        if (e_we) check_output("rnd m_wdata", m_wdata, e_wdata);
      end
      check_output("rnd if_valid", if_valid, e_ifv);
      check_output("rnd d_valid", d_valid, e_dv);
      if (e_ifv) check_output("rnd if_rdata", if_rdata, e_ifd);
      if (e_dv) check_output("rnd d_rdata", d_rdata, e_dd);
      check_output("rnd stall_if", stall_if, if_req && !e_ifv);
      check_output("rnd stall_mem", stall_mem, (d_read || d_write) && !e_dv);
      check_output("rnd timeout_err", timeout_err, e_terr);
      m_ack = (e_busy != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      prev_ifv = e_ifv;
      prev_dv  = e_dv;
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
